// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions so generator and checker agree on polynomial and tap positions.
package prbs_pkg;

  localparam int unsigned PRBS9_LEN   = 9;
  localparam int unsigned PRBS9_TAP_A = 8;
  localparam int unsigned PRBS9_TAP_B = 4;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Next PRBS9 bit (x^9+x^5+1) from a 9-bit window whose bit 0 is the newest.
  function automatic logic prbs9_fb(input logic [PRBS9_LEN-1:0] s);
    return s[PRBS9_TAP_A] ^ s[PRBS9_TAP_B];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/prbs9_checker.sv
// PRBS9 receive checker: self-synchronises on the incoming stream, then counts bits and
// errors against a free-running local LFSR, dropping lock when a window sees too many errors.
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_THR = 16,
  parameter int unsigned WIN_LEN  = 128,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             i_bit,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_sync_loss,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int unsigned FILL_W  = 4;
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned WIN_W   = 16;
  localparam int unsigned CMP_W   = WIN_W + 1;

  logic [1:0]           state_q, state_d;
  logic [PRBS9_LEN-1:0] hist_q, hist_d;
  logic [PRBS9_LEN-1:0] lfsr_q, lfsr_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_bits_q, win_bits_d;
  logic [WIN_W-1:0]     win_errs_q, win_errs_d;
  logic                 locked_q, locked_d;
  logic                 loss_q, loss_d;

  logic pred_bit_c, local_bit_c, bit_err_c, cnt_inc_c, err_inc_c;

  // Next-state: history shift, search/lock FSM, local LFSR and loss-of-lock window.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    lfsr_d      = lfsr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    loss_d      = 1'b0;
    bit_err_c   = 1'b0;
    cnt_inc_c   = 1'b0;
    err_inc_c   = 1'b0;
    pred_bit_c  = prbs9_fb(hist_q);
    local_bit_c = prbs9_fb(lfsr_q);

    if (enable) begin
      hist_d = {hist_q[PRBS9_LEN-2:0], i_bit};
      case (state_q)
        ST_FILL: begin
          if (fill_q == FILL_W'(PRBS9_LEN - 1)) begin
            fill_d  = '0;
            match_d = '0;
            state_d = ST_VERIFY;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        ST_VERIFY: begin
          // An all-zero history would predict zeros forever, so it never counts as a match.
          if ((i_bit == pred_bit_c) && (hist_q != '0)) begin
            if (match_q == MATCH_W'(LOCK_THR - 1)) begin
              state_d    = ST_LOCKED;
              lfsr_d     = {hist_q[PRBS9_LEN-2:0], i_bit};
              match_d    = '0;
              win_bits_d = '0;
              win_errs_d = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          lfsr_d    = {lfsr_q[PRBS9_LEN-2:0], local_bit_c};
          bit_err_c = (i_bit != local_bit_c);
          cnt_inc_c = 1'b1;
          err_inc_c = bit_err_c;
          // Loss takes priority over a window rollover landing on the same bit.
          if (({1'b0, win_errs_q} + CMP_W'(bit_err_c)) >= CMP_W'(LOSS_THR)) begin
            state_d    = ST_FILL;
            loss_d     = 1'b1;
            fill_d     = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (({1'b0, win_bits_q} + CMP_W'(1)) >= CMP_W'(WIN_LEN)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WIN_W'(1);
            win_errs_d = win_errs_q + WIN_W'(bit_err_c);
          end
        end
        default: begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
      endcase
    end

    if (i_clear) begin
      win_bits_d = '0;
      win_errs_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FILL;
      hist_q     <= '0;
      lfsr_q     <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      win_bits_q <= '0;
      win_errs_q <= '0;
      locked_q   <= 1'b0;
      loss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      lfsr_q     <= lfsr_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
      locked_q   <= locked_d;
      loss_q     <= loss_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc_c),
    .clr (i_clear),
    .q   (o_bit_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc_c),
    .clr (i_clear),
    .q   (o_err_count)
  );

  assign o_locked    = locked_q;
  assign o_sync_loss = loss_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// Scoreboard bench for prbs9_checker: default instance plus a 4-bit-counter instance for saturation.
module tb_prbs9_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, bit_a = 1'b0, clr_a = 1'b0;
  logic        en_b = 1'b0, bit_b = 1'b0, clr_b = 1'b0;
  logic        locked_a, loss_a, locked_b, loss_b;
  logic [31:0] bc_a, ec_a;
  logic [3:0]  bc_b, ec_b;

  always #5 clk = ~clk;

  prbs9_checker u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .enable      (en_a),
    .i_bit       (bit_a),
    .i_clear     (clr_a),
    .o_locked    (locked_a),
    .o_sync_loss (loss_a),
    .o_bit_count (bc_a),
    .o_err_count (ec_a)
  );

  prbs9_checker #(.CNT_W(4), .LOSS_THR(128)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .enable      (en_b),
    .i_bit       (bit_b),
    .i_clear     (clr_b),
    .o_locked    (locked_b),
    .o_sync_loss (loss_b),
    .o_bit_count (bc_b),
    .o_err_count (ec_b)
  );

  typedef struct packed {
    logic        inst;
    logic        locked;
    logic        loss;
    logic [31:0] bc;
    logic [31:0] ec;
    logic [7:0]  pulses;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned pulses_a = 0;
  int unsigned pulses_b = 0;
  logic [8:0]  gen_a = 9'd1;
  logic [8:0]  gen_b = 9'd1;

  // Reference PRBS9 generator: new bit is s[8]^s[4], shifted in at bit 0.
  function automatic logic [8:0] prbs_adv(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  task automatic push(input string nm, input logic inst, input logic lk, input logic ls,
                      input int unsigned bc, input int unsigned ec, input int unsigned pl);
    exp_t e;
    e.inst   = inst;
    e.locked = lk;
    e.loss   = ls;
    e.bc     = 32'(bc);
    e.ec     = 32'(ec);
    e.pulses = 8'(pl);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive_a(input logic b, input logic clr);
    repeat (3) @(posedge clk);
    #1 en_a = 1'b1; bit_a = b; clr_a = clr;
    @(posedge clk);
    #1 en_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic drive_b(input logic b, input logic clr);
    repeat (3) @(posedge clk);
    #1 en_b = 1'b1; bit_b = b; clr_b = clr;
    @(posedge clk);
    #1 en_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic send_a(input logic flip);
    gen_a = prbs_adv(gen_a);
    drive_a(gen_a[0] ^ flip, 1'b0);
  endtask

  task automatic send_b(input logic flip, input logic clr);
    gen_b = prbs_adv(gen_b);
    drive_b(gen_b[0] ^ flip, clr);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: counts sync-loss pulses and checks one queued expectation per falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    string       nm;
    logic        gl, gs;
    logic [31:0] gbc, gec;
    int unsigned gp;
    logic        bad;
    if (loss_a === 1'b1) pulses_a++;
    if (loss_b === 1'b1) pulses_b++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.inst) begin
        gl = locked_b; gs = loss_b; gbc = 32'(bc_b); gec = 32'(ec_b); gp = pulses_b;
      end else begin
        gl = locked_a; gs = loss_a; gbc = bc_a; gec = ec_a; gp = pulses_a;
      end
      checks++;
      bad = 1'b0;
      if (gl !== e.locked) bad = 1'b1;
      if (gs !== e.loss) bad = 1'b1;
      if (gbc !== e.bc) bad = 1'b1;
      if (gec !== e.ec) bad = 1'b1;
      if (gp != 32'(e.pulses)) bad = 1'b1;
      if (bad) begin
        errors++;
        $display("FAIL %s: got locked=%0b loss=%0b bits=%0d errs=%0d pulses=%0d, want locked=%0b loss=%0b bits=%0d errs=%0d pulses=%0d",
                 nm, gl, gs, gbc, gec, gp, e.locked, e.loss, e.bc, e.ec, e.pulses);
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 push("reset", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Acquisition and clean run
    repeat (24) send_a(1'b0);
    push("t1_prelock", 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send_a(1'b0);
    push("t1_lock", 1'b0, 1'b1, 1'b0, 0, 0, 0);
    repeat (1000) send_a(1'b0);
    push("t1_run", 1'b0, 1'b1, 1'b0, 1000, 0, 0);

    // Single line error
    send_a(1'b1);
    push("t2_flip", 1'b0, 1'b1, 1'b0, 1001, 1, 0);
    repeat (50) send_a(1'b0);
    push("t2_after", 1'b0, 1'b1, 1'b0, 1051, 1, 0);

    // Clear without enable, then an error burst that forces re-search
    @(posedge clk);
    #1 clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    push("t3_clear", 1'b0, 1'b1, 1'b0, 0, 0, 0);
    repeat (9) send_a(1'b0);
    repeat (7) send_a(1'b1);
    push("t3_7err", 1'b0, 1'b1, 1'b0, 16, 7, 0);
    send_a(1'b1);
    push("t3_loss", 1'b0, 1'b0, 1'b1, 17, 8, 1);
    send_a(1'b0);
    push("t3_fill", 1'b0, 1'b0, 1'b0, 17, 8, 1);
    repeat (23) send_a(1'b0);
    push("t3_prerelock", 1'b0, 1'b0, 1'b0, 17, 8, 1);
    send_a(1'b0);
    push("t3_relock", 1'b0, 1'b1, 1'b0, 17, 8, 1);
    repeat (10) send_a(1'b0);
    push("t3_run", 1'b0, 1'b1, 1'b0, 27, 8, 1);

    // Asynchronous reset while locked
    @(posedge clk);
    #2 rst = 1'b0;
    push("t6_async", 1'b0, 1'b0, 1'b0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (24) send_a(1'b0);
    push("t6_prelock", 1'b0, 1'b0, 1'b0, 0, 0, 1);
    send_a(1'b0);
    push("t6_relock", 1'b0, 1'b1, 1'b0, 0, 0, 1);
    repeat (5) send_a(1'b0);
    push("t6_run", 1'b0, 1'b1, 1'b0, 5, 0, 1);

    // Constant inputs never lock
    pulse_reset();
    repeat (60) drive_a(1'b0, 1'b0);
    push("t4_zero", 1'b0, 1'b0, 1'b0, 0, 0, 1);
    pulse_reset();
    repeat (60) drive_a(1'b1, 1'b0);
    push("t4_one", 1'b0, 1'b0, 1'b0, 0, 0, 1);

    // Saturation and clear-with-enable on the 4-bit instance
    pulse_reset();
    repeat (24) send_b(1'b0, 1'b0);
    push("t5_prelock", 1'b1, 1'b0, 1'b0, 0, 0, 0);
    send_b(1'b0, 1'b0);
    push("t5_lock", 1'b1, 1'b1, 1'b0, 0, 0, 0);
    repeat (14) send_b(1'b1, 1'b0);
    push("t5_14", 1'b1, 1'b1, 1'b0, 14, 14, 0);
    repeat (6) send_b(1'b1, 1'b0);
    push("t5_sat", 1'b1, 1'b1, 1'b0, 15, 15, 0);
    send_b(1'b1, 1'b1);
    push("t5_clear", 1'b1, 1'b1, 1'b0, 0, 0, 0);
    send_b(1'b0, 1'b0);
    push("t5_after", 1'b1, 1'b1, 1'b0, 1, 0, 0);

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
